// File: rtl/dtcm_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_store_buffer_pkg
// Brief    : Shared constants, drain-FSM state type and strobe helper for the
//            DTCM store buffer.
// Revision : 1.0 - initial release
// ============================================================================
package dtcm_store_buffer_pkg;

    localparam int c_DATA_SIZE = 32;
    localparam int c_SB_DEPTH  = 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } drain_state_t;

    function automatic logic [3:0] byte_strobe(input logic [1:0] lane);
        byte_strobe = 4'b0001 << lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtcm_sb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_sb_fifo
// Brief    : In-order store-entry FIFO; exposes every slot so the parent can
//            run the load-forwarding compare against pending stores.
// Revision : 1.0 - initial release
// ============================================================================
module dtcm_sb_fifo
    import dtcm_store_buffer_pkg::*;
#(
    parameter int SB_DEPTH = c_SB_DEPTH,
    parameter int AW       = c_DATA_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        i_push,
    input  logic [AW-1:0]               i_push_addr,
    input  logic [7:0]                  i_push_data,
    input  logic                        i_pop,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(SB_DEPTH):0]   o_count,
    output logic [$clog2(SB_DEPTH)-1:0] o_rd_ptr,
    output logic [SB_DEPTH-1:0]         o_valid,
    output logic [SB_DEPTH-1:0][AW-1:0] o_addr,
    output logic [SB_DEPTH-1:0][7:0]    o_data
);

    localparam int c_PW = $clog2(SB_DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [SB_DEPTH-1:0][AW-1:0] r_addr;
    logic [SB_DEPTH-1:0][7:0]    r_data;
    logic [SB_DEPTH-1:0]         r_valid;
    logic [c_PW-1:0]             r_wr_ptr;
    logic [c_PW-1:0]             r_rd_ptr;
    logic [c_CW-1:0]             r_count;
    logic                        w_push;
    logic                        w_pop;

    assign o_full   = (r_count == c_CW'(SB_DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;
    assign o_valid  = r_valid;
    assign o_addr   = r_addr;
    assign o_data   = r_data;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Push and pop never hit the same slot: that would need full and empty at once.
            if (w_push) begin
                r_addr[r_wr_ptr]  <= i_push_addr;
                r_data[r_wr_ptr]  <= i_push_data;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtcm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_store_buffer
// Brief    : Writeback byte-store buffer draining to the DTCM SRAM port, with
//            youngest-match forwarding to exe-stage load probes.
// Revision : 1.0 - initial release
// ============================================================================
module dtcm_store_buffer
    import dtcm_store_buffer_pkg::*;
#(
    parameter int SB_DEPTH = c_SB_DEPTH,
    parameter int AW       = c_DATA_SIZE
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          sb_en,
    input  logic [AW-1:0] dtcm_addr,
    input  logic [7:0]    sb_data,
    output logic          sb_full,
    output logic          sb_empty,
    output logic          ovf_err,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_valid,
    output logic          ld_hit,
    output logic [7:0]    ld_byte
);

    localparam int c_PW = $clog2(SB_DEPTH);
    localparam int c_CW = c_PW + 1;

    drain_state_t                r_state;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [c_CW-1:0]             w_count;
    logic [c_PW-1:0]             w_rd_ptr;
    logic [c_PW-1:0]             w_nxt_ptr;
    logic [c_PW-1:0]             w_idx;
    logic [SB_DEPTH-1:0]         w_valid;
    logic [SB_DEPTH-1:0][AW-1:0] w_addr;
    logic [SB_DEPTH-1:0][7:0]    w_data;
    logic                        w_load;
    logic [AW-1:0]               w_load_addr;
    logic [7:0]                  w_load_data;
    logic                        w_fwd_hit;
    logic [7:0]                  w_fwd_byte;

    assign w_push    = sb_en && !w_full;
    assign w_pop     = (r_state == S_REQ) && mem_ready;
    assign w_nxt_ptr = w_rd_ptr + c_PW'(1);
    assign sb_full   = w_full;
    assign sb_empty  = w_empty;

    dtcm_sb_fifo #(
        .SB_DEPTH (SB_DEPTH),
        .AW       (AW)
    ) u_fifo (
        .clk         (clk),
        .rst_        (rst_),
        .i_push      (w_push),
        .i_push_addr (dtcm_addr),
        .i_push_data (sb_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_rd_ptr    (w_rd_ptr),
        .o_valid     (w_valid),
        .o_addr      (w_addr),
        .o_data      (w_data)
    );

    // Next offer source: head when idle, head+1 after a pop, or the incoming
    // store when it is the only entry left after the pop.
    always_comb begin
        w_load      = 1'b0;
        w_load_addr = w_addr[w_rd_ptr];
        w_load_data = w_data[w_rd_ptr];
        case (r_state)
            S_IDLE: w_load = !w_empty;
            S_REQ: begin
                if (mem_ready) begin
                    if (w_count > c_CW'(1)) begin
                        w_load      = 1'b1;
                        w_load_addr = w_addr[w_nxt_ptr];
                        w_load_data = w_data[w_nxt_ptr];
                    end else if (w_push) begin
                        w_load      = 1'b1;
                        w_load_addr = dtcm_addr;
                        w_load_data = sb_data;
                    end
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state   <= S_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (w_load) begin
            r_state   <= S_REQ;
            mem_req   <= 1'b1;
            mem_addr  <= {w_load_addr[AW-1:2], 2'b00};
            mem_wdata <= {4{w_load_data}};
            mem_wstrb <= byte_strobe(w_load_addr[1:0]);
        end else if (w_pop) begin
            r_state   <= S_IDLE;
            mem_req   <= 1'b0;
        end
    end

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_byte = 8'h00;
        w_idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_idx = w_rd_ptr + i[c_PW-1:0];
            if (w_valid[w_idx] && (w_addr[w_idx] == ld_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_byte = w_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            ovf_err  <= 1'b0;
            ld_valid <= 1'b0;
            ld_hit   <= 1'b0;
            ld_byte  <= 8'h00;
        end else begin
            if (sb_en && w_full) begin
                ovf_err <= 1'b1;
            end
            ld_valid <= ld_req;
            ld_hit   <= ld_req && w_fwd_hit;
            ld_byte  <= ld_req ? w_fwd_byte : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtcm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtcm_store_buffer
// Brief    : Scoreboard bench for dtcm_store_buffer: expected DTCM writes are
//            queued at store time and matched when the handshake occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtcm_store_buffer;

    localparam int c_AW    = 32;
    localparam int c_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic            clk;
    logic            rst_;
    logic            sb_en;
    logic [c_AW-1:0] dtcm_addr;
    logic [7:0]      sb_data;
    logic            sb_full;
    logic            sb_empty;
    logic            ovf_err;
    logic            mem_req;
    logic [c_AW-1:0] mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic            ld_req;
    logic [c_AW-1:0] ld_addr;
    logic            ld_valid;
    logic            ld_hit;
    logic [7:0]      ld_byte;

    exp_t       sbq[$];
    logic [7:0] ref_mem [0:255];
    logic [7:0] dtcm    [0:255];
    int         n_tests = 0;
    int         n_fail  = 0;

    dtcm_store_buffer #(
        .SB_DEPTH (c_DEPTH),
        .AW       (c_AW)
    ) u_dut (
        .clk       (clk),
        .rst_      (rst_),
        .sb_en     (sb_en),
        .dtcm_addr (dtcm_addr),
        .sb_data   (sb_data),
        .sb_full   (sb_full),
        .sb_empty  (sb_empty),
        .ovf_err   (ovf_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_valid  (ld_valid),
        .ld_hit    (ld_hit),
        .ld_byte   (ld_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        exp_t e;
        sb_en     = 1'b1;
        dtcm_addr = a;
        sb_data   = d;
        if (sbq.size() < c_DEPTH) begin
            e.addr  = {a[31:2], 2'b00};
            e.wdata = {4{d}};
            e.wstrb = 4'b0001 << a[1:0];
            sbq.push_back(e);
            ref_mem[a[7:0]] = d;
        end
        tick();
        sb_en = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp_cycles);
        int n = 0;
        mem_ready = 1'b1;
        while (sbq.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_cycles >= 0) check(tag, 32'(n), 32'(exp_cycles));
        else                 check(tag, 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        sb_en     = 1'b0;
        ld_req    = 1'b0;
        mem_ready = 1'b0;
        rst_      = 1'b1;
        sbq.delete();
        tick();
        rst_ = 1'b0;
    endtask

    // Sampled mid-cycle: inputs and mem_* are stable until the coming rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_ && mem_req && mem_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_req", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_mem_addr", mem_addr, e.addr);
                check("sb_mem_wdata", mem_wdata, e.wdata);
                check("sb_mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                for (int l = 0; l < 4; l++) begin
                    if (mem_wstrb[l]) dtcm[{mem_addr[7:2], 2'(l)}] = mem_wdata[8*l +: 8];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          guard;
        rst_      = 1'b1;
        sb_en     = 1'b0;
        dtcm_addr = '0;
        sb_data   = '0;
        mem_ready = 1'b0;
        ld_req    = 1'b0;
        ld_addr   = '0;
        tick();
        tick();
        rst_ = 1'b0;

        // Reset state
        check("rst_sb_full", 32'(sb_full), 32'd0);
        check("rst_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_ld_valid", 32'(ld_valid), 32'd0);
        check("rst_ld_hit", 32'(ld_hit), 32'd0);
        check("rst_ld_byte", 32'(ld_byte), 32'd0);

        // Single store, first request one cycle after enqueue
        mem_ready = 1'b1;
        store(32'h13, 8'hA5);
        check("t1_req_not_yet", 32'(mem_req), 32'd0);
        tick();
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_wstrb", 32'(mem_wstrb), 32'h8);
        check("t1_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        check("t1_sb_empty", 32'(sb_empty), 32'd1);
        check("t1_req_drop", 32'(mem_req), 32'd0);

        // Fill, overflow, back-to-back drain
        do_reset();
        for (int i = 0; i < 4; i++) store(32'(i), 8'h30 + 8'(i));
        check("t2_sb_full", 32'(sb_full), 32'd1);
        store(32'h4, 8'h99);
        check("t2_ovf_err", 32'(ovf_err), 32'd1);
        check("t2_still_full", 32'(sb_full), 32'd1);
        drain("t2_b2b_cycles", 4);
        check("t2_empty", 32'(sb_empty), 32'd1);

        // Forwarding
        do_reset();
        store(32'h20, 8'h11);
        store(32'h20, 8'h22);
        ld_req  = 1'b1;
        ld_addr = 32'h20;
        tick();
        check("t3_ld_valid", 32'(ld_valid), 32'd1);
        check("t3_ld_hit", 32'(ld_hit), 32'd1);
        check("t3_ld_youngest", 32'(ld_byte), 32'h22);
        ld_addr = 32'h21;
        tick();
        check("t3_miss_valid", 32'(ld_valid), 32'd1);
        check("t3_miss_hit", 32'(ld_hit), 32'd0);
        check("t3_miss_byte", 32'(ld_byte), 32'd0);
        ld_addr = 32'h24;
        store(32'h24, 8'h77);
        check("t3_same_cyc_hit", 32'(ld_hit), 32'd0);
        tick();
        check("t3_new_hit", 32'(ld_hit), 32'd1);
        check("t3_new_byte", 32'(ld_byte), 32'h77);
        ld_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("t3_idle_valid", 32'(ld_valid), 32'd0);
        check("t3_idle_hit", 32'(ld_hit), 32'd0);
        check("t3_idle_byte", 32'(ld_byte), 32'd0);
        ld_req  = 1'b1;
        ld_addr = 32'h20;
        tick();
        check("t3_pop_hit", 32'(ld_hit), 32'd1);
        check("t3_pop_byte", 32'(ld_byte), 32'h22);
        ld_req = 1'b0;
        drain("t3_drain", -1);

        // Overflow while a pop happens in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) store(32'h8 + 32'(i), 8'h50 + 8'(i));
        mem_ready = 1'b1;
        store(32'hC, 8'hEE);
        mem_ready = 1'b0;
        check("t4_ovf_err", 32'(ovf_err), 32'd1);
        check("t4_not_full", 32'(sb_full), 32'd0);
        check("t4_not_empty", 32'(sb_empty), 32'd0);
        drain("t4_count3", 3);

        // Stall stability, then reset mid-hold
        do_reset();
        store(32'h45, 8'h5C);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_req_hold", 32'(mem_req), 32'd1);
            check("t5_addr_hold", mem_addr, 32'h44);
            check("t5_wdata_hold", mem_wdata, 32'h5C5C5C5C);
            check("t5_wstrb_hold", 32'(mem_wstrb), 32'h2);
            tick();
        end
        rst_ = 1'b1;
        #2;
        check("t5_async_req", 32'(mem_req), 32'd0);
        check("t5_async_empty", 32'(sb_empty), 32'd1);
        check("t5_async_wstrb", 32'(mem_wstrb), 32'd0);
        sbq.delete();
        tick();
        rst_ = 1'b0;

        // Random readiness against a byte-array reference
        do_reset();
        for (int b = 8'h40; b < 8'h50; b++) begin
            ref_mem[b] = 8'h00;
            dtcm[b]    = 8'h00;
        end
        for (int i = 0; i < 10; i++) begin
            guard = 0;
            while (sbq.size() >= c_DEPTH && guard < 100) begin
                mem_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            mem_ready = 1'($urandom_range(0, 1));
            a = 32'h40 + 32'($urandom_range(0, 15));
            store(a, 8'($urandom));
        end
        drain("t6_drain", -1);
        check("t6_no_ovf", 32'(ovf_err), 32'd0);
        for (int b = 8'h40; b < 8'h50; b++) begin
            check("t6_dtcm_byte", 32'(dtcm[b]), 32'(ref_mem[b]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
